// File: rtl/uart_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_sys_pkg
// Description : Shared controller states, command bytes and operand addresses.
// Revision    : 1.0
// ============================================================================
package uart_sys_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        ALU_A    = 4'd5,
        ALU_B    = 4'd6,
        ALU_F    = 4'd7,
        ALU_WAIT = 4'd8,
        SEND_LO  = 4'd9,
        SEND_HI  = 4'd10
    } state_t;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    function automatic logic is_alu_cmd(input logic [7:0] cmd);
        return (cmd == CMD_ALU_OP) || (cmd == CMD_ALU_NOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_tx_sender.sv
`default_nettype none
// ============================================================================
// Module      : cmd_tx_sender
// Description : Response byte sequencing towards the TX FIFO with FIFO_FULL
//               backpressure (low byte first, then optional high byte).
// Revision    : 1.0
// ============================================================================
module cmd_tx_sender #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_send_lo,
    input  logic                    i_send_hi,
    input  logic [2*DATA_WIDTH-1:0] i_result,
    input  logic                    i_fifo_full,
    output logic [DATA_WIDTH-1:0]   o_tx_p_data,
    output logic                    o_tx_d_vld,
    output logic                    o_sent
);

    logic [DATA_WIDTH-1:0] w_byte;
    logic [DATA_WIDTH-1:0] r_tx_p_data;
    logic                  r_tx_d_vld;

    assign w_byte = i_send_hi ? i_result[2*DATA_WIDTH-1:DATA_WIDTH]
                              : i_result[DATA_WIDTH-1:0];

    // A byte leaves in the first send cycle where the FIFO has room.
    assign o_sent = (i_send_lo | i_send_hi) & ~i_fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_p_data <= '0;
            r_tx_d_vld  <= 1'b0;
        end else begin
            r_tx_d_vld <= o_sent;
            if (o_sent) begin
                r_tx_p_data <= w_byte;
            end
        end
    end

    assign o_tx_p_data = r_tx_p_data;
    assign o_tx_d_vld  = r_tx_d_vld;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : UART command-frame decoder driving register file, ALU and
//               TX FIFO. Optional inter-byte timeout: CMD_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module uart_cmd_ctrl
    import uart_sys_pkg::*;
#(
    parameter int          DATA_WIDTH  = 8,
    parameter int          ADDR_WIDTH  = 4,
    parameter int          FUN_WIDTH   = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd5000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
    input  logic                    RF_RD_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   RF_ADDR,
    output logic                    RF_WR_EN,
    output logic                    RF_RD_EN,
    output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    state_t r_state, w_next_state;

    logic [7:0]              w_cmd;
    logic                    w_sent;
    logic                    w_timeout;
    logic                    w_frame_wait;

    logic [ADDR_WIDTH-1:0]   r_rf_addr,     w_rf_addr;
    logic                    r_rf_wr_en,    w_rf_wr_en;
    logic                    r_rf_rd_en,    w_rf_rd_en;
    logic [DATA_WIDTH-1:0]   r_rf_wr_data,  w_rf_wr_data;
    logic                    r_alu_en,      w_alu_en;
    logic [FUN_WIDTH-1:0]    r_alu_fun,     w_alu_fun;
    logic                    r_clk_gate_en, w_clk_gate_en;
    logic [2*DATA_WIDTH-1:0] r_result,      w_result;
    logic                    r_two_byte,    w_two_byte;

    assign w_cmd = 8'(RX_P_DATA);

    always_comb begin
        w_frame_wait = 1'b0;
        case (r_state)
            WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_F: w_frame_wait = 1'b1;
            default:                                        w_frame_wait = 1'b0;
        endcase
    end

`ifdef CMD_TIMEOUT_EN
    logic [15:0] r_timeout_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_timeout_cnt <= '0;
        end else if (RX_D_VLD || !w_frame_wait) begin
            r_timeout_cnt <= '0;
        end else begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYC-th silent cycle; a byte arriving that cycle still wins.
    assign w_timeout = w_frame_wait && !RX_D_VLD
                       && (r_timeout_cnt == TIMEOUT_CYC - 16'd1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (w_cmd)
                        CMD_RF_WR:   w_next_state = WR_ADDR;
                        CMD_RF_RD:   w_next_state = RD_ADDR;
                        CMD_ALU_OP:  w_next_state = ALU_A;
                        CMD_ALU_NOP: w_next_state = ALU_F;
                        default:     w_next_state = IDLE;
                    endcase
                end
            end
            WR_ADDR:  if (RX_D_VLD)    w_next_state = WR_DATA;
            WR_DATA:  if (RX_D_VLD)    w_next_state = IDLE;
            RD_ADDR:  if (RX_D_VLD)    w_next_state = RD_WAIT;
            RD_WAIT:  if (RF_RD_VLD)   w_next_state = SEND_LO;
            ALU_A:    if (RX_D_VLD)    w_next_state = ALU_B;
            ALU_B:    if (RX_D_VLD)    w_next_state = ALU_F;
            ALU_F:    if (RX_D_VLD)    w_next_state = ALU_WAIT;
            ALU_WAIT: if (ALU_OUT_VLD) w_next_state = SEND_LO;
            SEND_LO:  if (w_sent)      w_next_state = r_two_byte ? SEND_HI : IDLE;
            SEND_HI:  if (w_sent)      w_next_state = IDLE;
            default:                   w_next_state = IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = IDLE;
        end
    end

    always_comb begin
        w_rf_addr     = r_rf_addr;
        w_rf_wr_en    = 1'b0;
        w_rf_rd_en    = 1'b0;
        w_rf_wr_data  = r_rf_wr_data;
        w_alu_en      = 1'b0;
        w_alu_fun     = r_alu_fun;
        w_clk_gate_en = r_clk_gate_en;
        w_result      = r_result;
        w_two_byte    = r_two_byte;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD && is_alu_cmd(w_cmd)) begin
                    w_clk_gate_en = 1'b1;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_rf_addr = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_rf_wr_en   = 1'b1;
                    w_rf_wr_data = RX_P_DATA;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_rf_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rf_rd_en = 1'b1;
                end
            end
            RD_WAIT: begin
                if (RF_RD_VLD) begin
                    w_result   = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
                    w_two_byte = 1'b0;
                end
            end
            ALU_A, ALU_B: begin
                if (RX_D_VLD) begin
                    w_rf_addr    = (r_state == ALU_A) ? ADDR_WIDTH'(OPA_ADDR)
                                                      : ADDR_WIDTH'(OPB_ADDR);
                    w_rf_wr_en   = 1'b1;
                    w_rf_wr_data = RX_P_DATA;
                end
            end
            ALU_F: begin
                if (RX_D_VLD) begin
                    w_alu_fun = RX_P_DATA[FUN_WIDTH-1:0];
                    w_alu_en  = 1'b1;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    w_result      = ALU_OUT;
                    w_two_byte    = 1'b1;
                    w_clk_gate_en = 1'b0;
                end
            end
            default: begin
            end
        endcase
        if (w_timeout) begin
            w_clk_gate_en = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rf_addr     <= '0;
            r_rf_wr_en    <= 1'b0;
            r_rf_rd_en    <= 1'b0;
            r_rf_wr_data  <= '0;
            r_alu_en      <= 1'b0;
            r_alu_fun     <= '0;
            r_clk_gate_en <= 1'b0;
            r_result      <= '0;
            r_two_byte    <= 1'b0;
        end else begin
            r_rf_addr     <= w_rf_addr;
            r_rf_wr_en    <= w_rf_wr_en;
            r_rf_rd_en    <= w_rf_rd_en;
            r_rf_wr_data  <= w_rf_wr_data;
            r_alu_en      <= w_alu_en;
            r_alu_fun     <= w_alu_fun;
            r_clk_gate_en <= w_clk_gate_en;
            r_result      <= w_result;
            r_two_byte    <= w_two_byte;
        end
    end

    cmd_tx_sender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmd_tx_sender (
        .clk         (CLK),
        .rst         (RST),
        .i_send_lo   (r_state == SEND_LO),
        .i_send_hi   (r_state == SEND_HI),
        .i_result    (r_result),
        .i_fifo_full (FIFO_FULL),
        .o_tx_p_data (TX_P_DATA),
        .o_tx_d_vld  (TX_D_VLD),
        .o_sent      (w_sent)
    );

    assign RF_ADDR     = r_rf_addr;
    assign RF_WR_EN    = r_rf_wr_en;
    assign RF_RD_EN    = r_rf_rd_en;
    assign RF_WR_DATA  = r_rf_wr_data;
    assign ALU_EN      = r_alu_en;
    assign ALU_FUN     = r_alu_fun;
    assign CLK_GATE_EN = r_clk_gate_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Scoreboard bench for uart_cmd_ctrl (strobe events vs queue).
// Revision    : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int C_TIMEOUT = 5000;
    localparam int C_EV_WR   = 0;
    localparam int C_EV_RD   = 1;
    localparam int C_EV_ALU  = 2;
    localparam int C_EV_TX   = 3;

    logic        CLK;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RD_DATA;
    logic        RF_RD_VLD;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        FIFO_FULL;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN;
    logic        RF_RD_EN;
    logic [7:0]  RF_WR_DATA;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   tx_count   = 0;
    int   tx_cyc_last = 0;
    int   tx_cyc_prev = 0;
    int   tx_snap;

    uart_cmd_ctrl #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .FUN_WIDTH   (4),
        .TIMEOUT_CYC (16'd5000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .RF_RD_DATA  (RF_RD_DATA),
        .RF_RD_VLD   (RF_RD_VLD),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .FIFO_FULL   (FIFO_FULL),
        .RF_ADDR     (RF_ADDR),
        .RF_WR_EN    (RF_WR_EN),
        .RF_RD_EN    (RF_RD_EN),
        .RF_WR_DATA  (RF_WR_DATA),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic push(input int kind, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: got kind=%0d addr=%h data=%h, expected no strobe",
                     kind, addr, data);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                miscompares++;
                $display("FAIL strobe_event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every strobe the DUT raises is matched against the scoreboard.
    always @(negedge CLK) begin
        if (!RST) begin
            if (RF_WR_EN) check_ev(C_EV_WR, RF_ADDR, RF_WR_DATA);
            if (RF_RD_EN) check_ev(C_EV_RD, RF_ADDR, 8'h00);
            if (ALU_EN)   check_ev(C_EV_ALU, 4'h0, {4'h0, ALU_FUN});
            if (TX_D_VLD) begin
                check_ev(C_EV_TX, 4'h0, TX_P_DATA);
                tx_count++;
                tx_cyc_prev = tx_cyc_last;
                tx_cyc_last = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        RX_D_VLD  = 1'b1;
        RX_P_DATA = b;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    initial begin
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RD_DATA = '0; RF_RD_VLD = 1'b0;
        ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        repeat (3) tick();
        #1;
        check("reset_outputs", all_outs(), 32'h0);
        tick();
        RST = 1'b0;

        // Register write, address byte upper bits ignored in the second frame.
        push(C_EV_WR, 4'h5, 8'h3C);
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        push(C_EV_WR, 4'h9, 8'h5A);
        send_byte(8'hAA); send_byte(8'hF9); send_byte(8'h5A);
        repeat (3) tick();
        check("wr_no_tx", tx_count, 0);

        // Register read; a byte arriving in RD_WAIT is dropped.
        push(C_EV_RD, 4'h5, 8'h00);
        push(C_EV_TX, 4'h0, 8'h3C);
        send_byte(8'hBB); send_byte(8'h05);
        send_byte(8'hAA);
        RF_RD_DATA = 8'h3C; RF_RD_VLD = 1'b1;
        tick();
        RF_RD_VLD = 1'b0;
        repeat (5) tick();
        check("rd_tx_count", tx_count, 1);

        // ALU with operands; clock gate spans CC byte to ALU_OUT_VLD.
        push(C_EV_WR, 4'h0, 8'h12);
        push(C_EV_WR, 4'h1, 8'h34);
        push(C_EV_ALU, 4'h0, 8'h02);
        push(C_EV_TX, 4'h0, 8'h46);
        push(C_EV_TX, 4'h0, 8'h00);
        check("gate_before_cc", CLK_GATE_EN, 0);
        send_byte(8'hCC);
        #1;
        check("gate_after_cc", CLK_GATE_EN, 1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        tick();
        ALU_OUT = 16'h0046; ALU_OUT_VLD = 1'b1;
        #1;
        check("gate_in_alu_wait", CLK_GATE_EN, 1);
        tick();
        ALU_OUT_VLD = 1'b0;
        #1;
        check("gate_after_out_vld", CLK_GATE_EN, 0);
        repeat (5) tick();
        check("alu_tx_count", tx_count, 3);

        // ALU without operands under FIFO backpressure.
        push(C_EV_ALU, 4'h0, 8'h01);
        push(C_EV_TX, 4'h0, 8'hCD);
        push(C_EV_TX, 4'h0, 8'hAB);
        send_byte(8'hDD); send_byte(8'h01);
        FIFO_FULL = 1'b1;
        tick();
        ALU_OUT = 16'hABCD; ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        tx_snap = tx_count;
        repeat (10) tick();
        check("no_tx_while_full", tx_count, tx_snap);
        // RX byte in the same cycle FIFO_FULL drops must be ignored.
        FIFO_FULL = 1'b0; RX_D_VLD = 1'b1; RX_P_DATA = 8'hAA;
        tick();
        RX_D_VLD = 1'b0;
        repeat (4) tick();
        check("tx_after_release", tx_count, tx_snap + 2);
        check("tx_consecutive", tx_cyc_last - tx_cyc_prev, 1);

        // Unknown byte, then reset mid-frame, then a clean write.
        send_byte(8'h55);
        send_byte(8'hAA); send_byte(8'h07);
        RST = 1'b1;
        tick();
        #1;
        check("midframe_reset_outputs", all_outs(), 32'h0);
        RST = 1'b0;
        push(C_EV_WR, 4'h7, 8'hFF);
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'hFF);
        repeat (3) tick();

`ifdef CMD_TIMEOUT_EN
        send_byte(8'hAA);
        repeat (C_TIMEOUT) tick();
        send_byte(8'h05);
        send_byte(8'h11);
        repeat (3) tick();
        check("timeout_gate", CLK_GATE_EN, 0);
`endif

        repeat (5) tick();
        check("queue_empty", q.size(), 0);
        check("gate_idle_end", CLK_GATE_EN, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
